aes_wb_initiator: RTL and testbench
===================================

# aes_wb_initiator

Wishbone classic single-cycle initiator that lets on-chip logic issue register reads and writes to the AES accelerator's Wishbone responder port, with no Caravel management core involved. It sits beside the AES core in `accelerator_top`. A simple valid/ready command and response interface is converted into one Wishbone cycle per command. A bus-hang timeout is included so a non-acking responder cannot lock the initiator.

## Interface
Parameters:
- `ADDR_W`, default 28: Wishbone address width, matching the AES core's `io_bus_addr`.
- `TIMEOUT_CYCLES`, default 255: number of cycles with CYC high and no ACK before the cycle is aborted. Legal range is 1..65535.

Ports (clock and reset first):
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset. **Synchronous, active-high.**
- `cmd_valid` in 1: a command is present.
- `cmd_ready` out 1: the block accepts the command this cycle.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_sel` in 4: byte selects.
- `cmd_addr` in ADDR_W: target address.
- `cmd_data` in 32: write data.
- `rsp_valid` out 1: a response is present.
- `rsp_ready` in 1: the consumer takes the response.
- `rsp_data` out 32: read data. It is 0 for writes and for errors.
- `rsp_err` out 1: the cycle timed out.
- `wbm_cyc_o` out 1: Wishbone CYC.
- `wbm_stb_o` out 1: Wishbone STB.
- `wbm_we_o` out 1: Wishbone WE.
- `wbm_sel_o` out 4: Wishbone SEL.
- `wbm_adr_o` out ADDR_W: Wishbone address.
- `wbm_dat_o` out 32: Wishbone write data.
- `wbm_ack_i` in 1: Wishbone ACK from the responder.
- `wbm_dat_i` in 32: Wishbone read data from the responder.

## Operation
- FSM states are IDLE, BUS and RESP. Reset forces IDLE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, register we/sel/addr/data into the `wbm_*` outputs, set CYC=STB=1, clear the timeout counter, and go to BUS.
- **BUS**
  - CYC, STB, WE, SEL, ADR and DAT are held stable. `cmd_ready`=0.
  - On an edge where `wbm_ack_i`=1:
    - drop CYC and STB;
    - capture `rsp_data` (`wbm_dat_i` for reads, 0 for writes);
    - set `rsp_err`=0 and `rsp_valid`=1;
    - go to RESP.
  - Otherwise the counter increments. When it equals TIMEOUT_CYCLES-1 with no ACK:
    - drop CYC and STB;
    - set `rsp_data`=0, `rsp_err`=1 and `rsp_valid`=1;
    - go to RESP.
  - If ACK and the timeout occur on the same edge, ACK wins and `rsp_err`=0.
- **RESP**
  - `rsp_valid` is held with stable data until `rsp_valid & rsp_ready`, then go to IDLE.
  - `cmd_ready` stays 0 while in RESP.
- `wbm_ack_i` seen outside BUS is ignored.
- Counter width is 16 bits and it never wraps: it is cleared on every entry to BUS.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 from the first cycle after reset deasserts. All other outputs are 0.
- A command accepted at edge N gives CYC=STB=1 from edge N to edge N+1.
- An ACK sampled at edge M gives CYC=0 and `rsp_valid`=1 after edge M.
- Minimum command-to-response latency is 2 cycles, with combinational ACK in the first BUS cycle. Against the AES core's registered ACK it is 3 cycles.
- Throughput is at most one transaction per 3 cycles, because `rsp_ready` is consumed in RESP before the next accept.
- Reset mid-operation: CYC and STB deassert at the reset edge. The pending command and any pending response are discarded with no `rsp_valid`.

## Configuration
- `AES_WB_INIT_TIMEOUT_EN` defined: timeout counter and abort logic are present as described above.
- Not defined: the counter is removed and `rsp_err` is tied to 0. BUS waits for ACK indefinitely and TIMEOUT_CYCLES is ignored.

## Structure
- Shared package/header `accel_pkg` holds:
  - FSM state encodings (IDLE=2'd0, BUS=2'd1, RESP=2'd2);
  - the `AES_WB_ADDR_W` default (28);
  - the error data constant (32'h0).
- One natural sub-module: `wb_timeout_counter`, with clear, enable, and a `expired` flag at TIMEOUT_CYCLES-1. It is instantiated only under `AES_WB_INIT_TIMEOUT_EN`.
- Everything else stays in one always block for the FSM and registered outputs.

## Test plan
- **Write:** cmd we=1, addr=28'h0000010, data=32'hA5A5_5A5A, sel=4'hF. The responder ACKs 1 cycle after STB. Expect:
  - ADR/DAT/SEL/WE stable for the whole cycle;
  - exactly one ACKed cycle;
  - `rsp_valid` with `rsp_data`=0 and `rsp_err`=0.
- **Read:** cmd we=0, addr=28'h0000020. The responder returns 32'h1234_5678 with ACK. Expect `rsp_data`=32'h1234_5678 and `rsp_err`=0, with latency 3 cycles from accept.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles after the response. Expect:
  - `rsp_valid` and `rsp_data` held stable;
  - `cmd_ready`=0 throughout;
  - the next command accepted only after the handshake.
- **Timeout** (macro on, TIMEOUT_CYCLES=8, responder never ACKs): expect CYC high for exactly 8 cycles, then `rsp_err`=1 and `rsp_data`=0. With the macro off, CYC stays high for 1000 cycles.
- **Reset mid-cycle:** assert `wb_rst_i` during BUS. Expect:
  - CYC=STB=0 and `rsp_valid`=0 after the edge;
  - `cmd_ready`=1 one cycle after release;
  - a late ACK ignored.
- **ACK/timeout collision** (TIMEOUT_CYCLES=4, ACK on the 4th BUS cycle): expect `rsp_err`=0 and `rsp_data`=`wbm_dat_i`.

Source files
------------

// File: rtl/accel_pkg.sv
// accel_pkg: shared FSM encodings and constants for the AES Wishbone initiator
package accel_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } wb_state_t;
   localparam int AES_WB_ADDR_W = 28;
   localparam logic [31:0] WB_ERR_DATA = 32'h0;
endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: 16-bit bus-wait counter that flags the last allowed cycle and never wraps
module wb_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] count;
   assign expired = count == LAST;
   // Count waiting cycles, saturating at the expiry value until the next clear
   always_ff @(posedge clk)
      if (rst || clr) count <= '0;
      else if (en && !expired) count <= count + 16'd1;
endmodule

// File: rtl/aes_wb_initiator.sv
// aes_wb_initiator: valid/ready command port to Wishbone classic single-cycle initiator.
// Define AES_WB_INIT_TIMEOUT_EN to abort cycles not ACKed within TIMEOUT_CYCLES.
module aes_wb_initiator
   import accel_pkg::*;
#(
   parameter int ADDR_W         = AES_WB_ADDR_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [3:0]        cmd_sel,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic              rsp_err,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   output logic [ADDR_W-1:0] wbm_adr_o,
   output logic [31:0]       wbm_dat_o,
   input  logic              wbm_ack_i,
   input  logic [31:0]       wbm_dat_i
);
   wb_state_t state, state_nx;
   logic accept, expired, done;
   assign accept = cmd_valid & cmd_ready;
   assign done = wbm_ack_i | expired;
`ifdef AES_WB_INIT_TIMEOUT_EN
   wb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk(wb_clk_i),
      .rst(wb_rst_i),
      .clr(accept),
      .en(state == BUS),
      .expired(expired)
   );
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign expired = 1'b0;
`endif
   // State register; reset abandons any bus cycle or pending response
   always_ff @(posedge wb_clk_i)
      if (wb_rst_i) state <= IDLE;
      else state <= state_nx;
   // Next state: accept -> bus cycle -> hold response until consumed
   always_comb
      state_nx = state == IDLE ? (accept ? BUS : IDLE)
               : state == BUS  ? (done ? RESP : BUS)
               : state == RESP ? (rsp_ready ? IDLE : RESP)
               : IDLE;
   // Handshake and bus strobes decode directly from the state
   always_comb begin
      cmd_ready = state == IDLE && !wb_rst_i;
      wbm_cyc_o = state == BUS;
      wbm_stb_o = state == BUS;
      rsp_valid = state == RESP;
   end
   // Capture the command on accept and the response when the bus cycle ends; ACK beats timeout
   always_ff @(posedge wb_clk_i)
      if (wb_rst_i) begin
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         wbm_we_o  <= cmd_we;
         wbm_sel_o <= cmd_sel;
         wbm_adr_o <= cmd_addr;
         wbm_dat_o <= cmd_data;
      end else if (state == BUS && done) begin
         rsp_data <= wbm_ack_i && !wbm_we_o ? wbm_dat_i : WB_ERR_DATA;
         rsp_err  <= !wbm_ack_i;
      end
endmodule

// File: tb/tb_aes_wb_initiator.sv
// tb_aes_wb_initiator: vector table, hand sequences and random transactions against a response model
module tb_aes_wb_initiator;
   localparam int AW = 28;
   localparam int TO = 8;
   localparam int NEVER = 100000;

   typedef struct {
      int          lat;
      logic [31:0] data;
      logic        err;
      int          cycs;
      int          acks;
   } exp_t;

   typedef struct {
      logic          w;
      logic [3:0]    s;
      logic [AW-1:0] a;
      logic [31:0]   wd;
      int            d;
      logic [31:0]   rd;
      int            bp;
      exp_t          e;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0, late_ack = 1'b0;
   logic [3:0] cmd_sel = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [31:0] cmd_data = '0, dati = '0;
   logic cmd_ready, rsp_valid, rsp_err, cyc, stb, we, ack;
   logic [31:0] rsp_data, dato;
   logic [3:0] sel;
   logic [AW-1:0] adr;
   int ack_d = NEVER;
   int bus_cnt = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Responder: bus_cnt is the index of the current BUS cycle; ACK combinationally at index ack_d
   always @(posedge clk) bus_cnt <= cyc ? bus_cnt + 1 : 0;
   assign ack = late_ack | (cyc & stb & (bus_cnt == ack_d));

   aes_wb_initiator #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_we(cmd_we),
      .cmd_sel(cmd_sel),
      .cmd_addr(cmd_addr),
      .cmd_data(cmd_data),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .rsp_err(rsp_err),
      .wbm_cyc_o(cyc),
      .wbm_stb_o(stb),
      .wbm_we_o(we),
      .wbm_sel_o(sel),
      .wbm_adr_o(adr),
      .wbm_dat_o(dato),
      .wbm_ack_i(ack),
      .wbm_dat_i(dati)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: a responder ACKing in BUS cycle d answers unless the timeout window closes first
   function automatic exp_t model(input logic w, input int d, input logic [31:0] rd);
      exp_t e;
      bit acked;
      acked = 1'b1;
`ifdef AES_WB_INIT_TIMEOUT_EN
      acked = d < TO;
`endif
      e.lat  = acked ? d + 2 : TO + 1;
      e.cycs = acked ? d + 1 : TO;
      e.acks = acked ? 1 : 0;
      e.data = (acked && !w) ? rd : 32'h0;
      e.err  = !acked;
      return e;
   endfunction

   // Latency counts cycles from the accepting cycle to the first cycle showing rsp_valid
   task automatic txn(input logic w, input logic [3:0] s, input logic [AW-1:0] a, input logic [31:0] wd,
                      input int d, input logic [31:0] rd, input int bp, input exp_t e);
      int lat = 1;
      int cycs = 0;
      int acks = 0;
      int bad = 0;
      @(negedge clk);
      check("idle_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_we = w; cmd_sel = s; cmd_addr = a; cmd_data = wd;
      ack_d = d; dati = rd;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_we = ~w; cmd_sel = ~s; cmd_addr = ~a; cmd_data = ~wd;
      while (!rsp_valid && lat < 100) begin
         if (cyc) begin
            cycs++;
            if (ack) acks++;
            if (!stb || we !== w || sel !== s || adr !== a || dato !== wd) bad++;
         end
         if (cmd_ready) bad++;
         @(negedge clk);
         lat++;
      end
      check("rsp_latency", lat, e.lat);
      check("cyc_cycles", cycs, e.cycs);
      check("ack_count", acks, e.acks);
      check("bus_stable", bad, 0);
      check("rsp_data", rsp_data, e.data);
      check("rsp_err", rsp_err, e.err);
      check("cyc_after_rsp", cyc, 0);
      bad = 0;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_data !== e.data || rsp_err !== e.err || cmd_ready || cyc) bad++;
      end
      check("bp_hold", bad, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      ack_d = NEVER;
      check("rsp_released", rsp_valid, 0);
      check("ready_after_rsp", cmd_ready, 1);
   endtask

   initial begin
      vec_t tab[5];
      logic w;
      logic [3:0] s;
      logic [AW-1:0] a;
      logic [31:0] wd, rd;
      int d, bp;
      tab[0] = '{1'b1, 4'hF, 28'h0000010, 32'hA5A5_5A5A, 1, 32'hFFFF_FFFF, 0, exp_t'{3, 32'h0, 1'b0, 2, 1}};
      tab[1] = '{1'b0, 4'hF, 28'h0000020, 32'h0, 1, 32'h1234_5678, 0, exp_t'{3, 32'h1234_5678, 1'b0, 2, 1}};
      tab[2] = '{1'b0, 4'h3, 28'h0000024, 32'h0, 0, 32'hDEAD_BEEF, 10, exp_t'{2, 32'hDEAD_BEEF, 1'b0, 1, 1}};
      tab[3] = '{1'b0, 4'hC, 28'hFFFFFFC, 32'h0, TO - 1, 32'hCAFE_F00D, 1, exp_t'{TO + 1, 32'hCAFE_F00D, 1'b0, TO, 1}};
      tab[4] = '{1'b1, 4'h1, 28'h8000004, 32'h0BAD_F00D, 2, 32'h7777_7777, 2, exp_t'{4, 32'h0, 1'b0, 3, 1}};

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_cyc", cyc, 0);
      check("rst_stb", stb, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_we", we, 0);
      check("rst_sel", sel, 0);
      check("rst_adr", adr, 0);
      check("rst_dat", dato, 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", cmd_ready, 1);

      for (int i = 0; i < 5; i++)
         txn(tab[i].w, tab[i].s, tab[i].a, tab[i].wd, tab[i].d, tab[i].rd, tab[i].bp, tab[i].e);

`ifdef AES_WB_INIT_TIMEOUT_EN
      txn(1'b0, 4'hF, 28'h0000030, 32'h0, NEVER, 32'h5555_5555, 2, exp_t'{TO + 1, 32'h0, 1'b1, TO, 0});
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_addr = 28'h0000040; ack_d = NEVER;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
`else
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_addr = 28'h0000030; ack_d = NEVER;
      @(negedge clk);
      cmd_valid = 1'b0;
      d = 0;
      for (int i = 0; i < 1000; i++) begin
         if (cyc && stb && !rsp_valid) d++;
         @(negedge clk);
      end
      check("no_timeout_cyc_held", d, 1000);
`endif
      check("cyc_before_mid_reset", cyc, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_cyc", cyc, 0);
      check("mid_rst_stb", stb, 0);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_cmd_ready", cmd_ready, 0);
      rst = 1'b0;
      late_ack = 1'b1;
      @(negedge clk);
      check("ready_after_release", cmd_ready, 1);
      @(negedge clk);
      late_ack = 1'b0;
      check("late_ack_no_rsp", rsp_valid, 0);
      check("late_ack_no_cyc", cyc, 0);
      check("late_ack_still_ready", cmd_ready, 1);

      for (int i = 0; i < 40; i++) begin
         w  = 1'($urandom_range(0, 1));
         s  = 4'($urandom);
         a  = AW'($urandom);
         wd = $urandom;
         rd = $urandom;
         d  = $urandom_range(0, TO + 2);
         bp = $urandom_range(0, 3);
         txn(w, s, a, wd, d, rd, bp, model(w, d, rd));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
